// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, issue-controller FSM encoding, opcode constants.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;
    localparam int unsigned ALU_SEL_W = 3;
    localparam int unsigned ALU_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes double as the mux-bank select value.
    localparam logic [ALU_SEL_W-1:0] OP_0 = ALU_SEL_W'(0);
    localparam logic [ALU_SEL_W-1:0] OP_1 = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] OP_2 = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] OP_3 = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] OP_4 = ALU_SEL_W'(4);
    localparam logic [ALU_SEL_W-1:0] OP_5 = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] OP_6 = ALU_SEL_W'(6);
    localparam logic [ALU_SEL_W-1:0] OP_7 = ALU_SEL_W'(7);

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, mux-bank and result signals of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 3
);

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] mux_y;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_z;
    logic             res_n;
    logic             res_p;

    // Upstream requester plus the mux bank / downstream consumer.
    modport master (
        output in_valid, in_op, in_a, in_b, mux_y, res_ready,
        input  in_ready, sel, op_a, op_b, res_valid, res_data, res_z, res_n, res_p
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, mux_y, res_ready,
        output in_ready, sel, op_a, op_b, res_valid, res_data, res_z, res_n, res_p
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational zero / negative / even-parity flags for a WIDTH-bit value.
module alu_flag_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic             z_c,
    output logic             n_c,
    output logic             p_c
);

    assign z_c = (value == '0);
    assign n_c = value[WIDTH-1];
    assign p_c = ~^value;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller in front of the ALU mux bank: accept op, hold select
// for one execute cycle, register result with flags, count completed operations.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SEL_W = ALU_SEL_W,
    parameter int unsigned CNT_W = ALU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q,     state_d;
    logic [SEL_W-1:0] sel_q,       sel_d;
    logic [WIDTH-1:0] op_a_q,      op_a_d;
    logic [WIDTH-1:0] op_b_q,      op_b_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_z_q,     res_z_d;
    logic             res_n_q,     res_n_d;
    logic             res_p_q,     res_p_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    logic in_ready_c;
    logic accept_c;
    logic z_c, n_c, p_c;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .value (bus.mux_y),
        .z_c   (z_c),
        .n_c   (n_c),
        .p_c   (p_c)
    );

    // Ready is low through reset; in DONE it follows res_ready so a new op can overlap the handshake.
    assign in_ready_c = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.res_ready));
    assign accept_c   = bus.in_valid & in_ready_c;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_data_d  = res_data_q;
        res_z_d     = res_z_q;
        res_n_d     = res_n_q;
        res_p_d     = res_p_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;

        case (state_q)
            ST_IDLE: ;
            ST_EXEC: begin
                res_data_d  = bus.mux_y;
                res_z_d     = z_c;
                res_n_d     = n_c;
                res_p_d     = p_c;
                res_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c) begin
            sel_d   = bus.in_op;
            op_a_d  = bus.in_a;
            op_b_d  = bus.in_b;
            state_d = ST_EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_z_q     <= 1'b0;
            res_n_q     <= 1'b0;
            res_p_q     <= 1'b0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_data_q  <= res_data_d;
            res_z_q     <= res_z_d;
            res_n_q     <= res_n_d;
            res_p_q     <= res_p_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.sel       = sel_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_z     = res_z_q;
    assign bus.res_n     = res_n_q;
    assign bus.res_p     = res_p_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; a second instance with a 4-bit counter covers saturation.
module tb_alu_issue_ctrl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_issue_ctrl_if #(.WIDTH(8), .SEL_W(3)) bus   ();
    alu_issue_ctrl_if #(.WIDTH(8), .SEL_W(3)) bus_s ();
    logic [15:0] op_count;
    logic [3:0]  op_count_s;

    alu_issue_ctrl #(.WIDTH(8), .SEL_W(3), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (op_count)
    );

    alu_issue_ctrl #(.WIDTH(8), .SEL_W(3), .CNT_W(4)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_s),
        .op_count (op_count_s)
    );

    // Mux-bank model: slice input k carries bit i of function k.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    alu_fn = a + b;
            3'd1:    alu_fn = a - b;
            3'd2:    alu_fn = a | b;
            3'd3:    alu_fn = a & b;
            3'd4:    alu_fn = a ^ b;
            3'd5:    alu_fn = ~a;
            3'd6:    alu_fn = a << 1;
            default: alu_fn = b;
        endcase
    endfunction

    always_comb bus.mux_y   = alu_fn(bus.sel, bus.op_a, bus.op_b);
    always_comb bus_s.mux_y = bus_s.op_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one request for one cycle; returns on the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_op = '0; bus_s.in_a = '0; bus_s.in_b = '0; bus_s.res_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sel, bus.op_a, bus.op_b, bus.res_data} !== 27'd0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {bus.sel, bus.op_a, bus.op_b, bus.res_data});
        end
        checks++;
        if ({bus.res_valid, bus.res_z, bus.res_n, bus.res_p, bus.in_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {bus.res_valid, bus.res_z, bus.res_n, bus.res_p, bus.in_ready});
        end
        checks++;
        if (op_count !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle_ready: got %b expected 1", bus.in_ready);
        end
        // Accept op 3, then pull reset in the middle of EXEC.
        bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_a = 8'h5A; bus.in_b = 8'h0F;
        @(posedge clk);
        #2;
        checks++;
        if ({bus.sel, bus.op_a} !== {3'd3, 8'h5A}) begin
            errors++; $display("FAIL reset_pre_accept: got %h expected %h", {bus.sel, bus.op_a}, {3'd3, 8'h5A});
        end
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus.sel, bus.op_a, bus.op_b, bus.res_valid, bus.in_ready, op_count} !== 37'd0) begin
            errors++; $display("FAIL reset_mid_exec: got %h expected 0", {bus.sel, bus.op_a, bus.op_b, bus.res_valid, bus.in_ready, op_count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        issue(3'd3, 8'h5A, 8'h0F);
        @(negedge clk);
        checks++;
        if ({bus.res_valid, bus.res_data} !== {1'b1, 8'h0A}) begin
            errors++; $display("FAIL reset_first_op: got %h expected %h", {bus.res_valid, bus.res_data}, {1'b1, 8'h0A});
        end
        @(negedge clk);
        checks++;
        if (op_count !== 16'd1) begin
            errors++; $display("FAIL reset_first_count: got %0d expected 1", op_count);
        end
    endtask

    task automatic test_single_op();
        do_reset();
        bus.res_ready = 1'b1;
        issue(3'd2, 8'hF0, 8'h0F);
        checks++;
        if ({bus.res_valid, bus.in_ready, bus.sel, bus.op_a, bus.op_b} !== {1'b0, 1'b0, 3'd2, 8'hF0, 8'h0F}) begin
            errors++; $display("FAIL single_exec: got %h expected %h", {bus.res_valid, bus.in_ready, bus.sel, bus.op_a, bus.op_b}, {1'b0, 1'b0, 3'd2, 8'hF0, 8'h0F});
        end
        @(negedge clk);
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_z, bus.res_n, bus.res_p} !== {1'b1, 8'hFF, 3'b011}) begin
            errors++; $display("FAIL single_result: got %h expected %h", {bus.res_valid, bus.res_data, bus.res_z, bus.res_n, bus.res_p}, {1'b1, 8'hFF, 3'b011});
        end
        @(negedge clk);
        checks++;
        if ({bus.res_valid, bus.in_ready, op_count} !== {1'b0, 1'b1, 16'd1}) begin
            errors++; $display("FAIL single_done: got %h expected %h", {bus.res_valid, bus.in_ready, op_count}, {1'b0, 1'b1, 16'd1});
        end
    endtask

    task automatic test_backpressure();
        bus.res_ready = 1'b0;
        issue(3'd3, 8'hF0, 8'h0F);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.res_valid, bus.res_data, bus.res_z, bus.res_n, bus.res_p, bus.in_ready, bus.sel, op_count} !==
                {1'b1, 8'h00, 3'b101, 1'b0, 3'd3, 16'd1}) begin
                errors++; $display("FAIL backpressure_hold[%0d]: got %h expected %h", i,
                    {bus.res_valid, bus.res_data, bus.res_z, bus.res_n, bus.res_p, bus.in_ready, bus.sel, op_count},
                    {1'b1, 8'h00, 3'b101, 1'b0, 3'd3, 16'd1});
            end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.res_valid, op_count} !== {1'b0, 16'd2}) begin
            errors++; $display("FAIL backpressure_release: got %h expected %h", {bus.res_valid, op_count}, {1'b0, 16'd2});
        end
        @(negedge clk);
        checks++;
        if (op_count !== 16'd2) begin
            errors++; $display("FAIL backpressure_once: got %0d expected 2", op_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        logic [7:0] as  [3];
        logic [7:0] bs  [3];
        logic [7:0] exp [3];
        ops = '{3'd1, 3'd2, 3'd3};
        as  = '{8'h40, 8'h0A, 8'hF3};
        bs  = '{8'h10, 8'hA0, 8'h5F};
        exp = '{8'h30, 8'hAA, 8'h53};
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = ops[0]; bus.in_a = as[0]; bus.in_b = bs[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.sel, bus.res_valid} !== {ops[i], 1'b0}) begin
                errors++; $display("FAIL b2b_exec[%0d]: got %h expected %h", i, {bus.sel, bus.res_valid}, {ops[i], 1'b0});
            end
            if (i < 2) begin
                bus.in_op = ops[i+1]; bus.in_a = as[i+1]; bus.in_b = bs[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({bus.res_valid, bus.res_data} !== {1'b1, exp[i]}) begin
                errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, {bus.res_valid, bus.res_data}, {1'b1, exp[i]});
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.res_valid, op_count} !== {1'b0, 16'd5}) begin
            errors++; $display("FAIL b2b_count: got %h expected %h", {bus.res_valid, op_count}, {1'b0, 16'd5});
        end
    endtask

    task automatic test_sel_sweep();
        logic [7:0] exp [8];
        exp = '{8'h91, 8'hE7, 8'h7D, 8'h14, 8'h69, 8'hC3, 8'h78, 8'h55};
        bus.res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            issue(3'(k), 8'h3C, 8'h55);
            @(negedge clk);
            checks++;
            if ({bus.res_valid, bus.res_data} !== {1'b1, exp[k]}) begin
                errors++; $display("FAIL sweep_sel%0d: got %h expected %h", k, {bus.res_valid, bus.res_data}, {1'b1, exp[k]});
            end
            @(negedge clk);
        end
        checks++;
        if (op_count !== 16'd13) begin
            errors++; $display("FAIL sweep_count: got %0d expected 13", op_count);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        bus_s.in_valid = 1'b1; bus_s.res_ready = 1'b1; bus_s.in_op = 3'd7; bus_s.in_a = 8'h81; bus_s.in_b = 8'h00;
        repeat (29) @(posedge clk);
        @(negedge clk);
        checks++;
        if (op_count_s !== 4'hE) begin
            errors++; $display("FAIL sat_count14: got %h expected e", op_count_s);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (op_count_s !== 4'hF) begin
            errors++; $display("FAIL sat_count15: got %h expected f", op_count_s);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (op_count_s !== 4'hF) begin
            errors++; $display("FAIL sat_count17: got %h expected f", op_count_s);
        end
        bus_s.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus_s.res_valid, bus_s.res_data, op_count_s} !== {1'b0, 8'h81, 4'hF}) begin
            errors++; $display("FAIL sat_hold: got %h expected %h", {bus_s.res_valid, bus_s.res_data, op_count_s}, {1'b0, 8'h81, 4'hF});
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_back_to_back();
        test_sel_sweep();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
